instr_fetch: RTL
================

# instr_fetch

Instruction fetch stage that sits directly upstream of the 32-entry instruction memory. It owns the program counter and drives the memory address. It captures each returned instruction word, together with its PC, into a 2-entry queue and presents them in order to the decode stage over a valid/ready handshake. Fetch runs from a start point to a configurable last address, and a branch redirect flushes the queue and restarts fetch at a new PC.

## Interface
- M, 32, instruction word width
- AW, 5, PC / memory address width (memory depth 2^AW)
- LAST_PC, 31, final address fetched before entering DONE
- clk  in  1  rising-edge clock; one clock domain
- rst_n  in  1  reset, asynchronous, active-low
- en  in  1  fetch enable; level sensitive
- pc_out  out  AW  address to instruction memory; registered
- mem_data  in  M  instruction word from memory; combinational from pc_out, same cycle
- redirect_valid  in  1  one-cycle redirect request
- redirect_pc  in  AW  new fetch address, sampled with redirect_valid
- out_valid  out  1  queue head is valid
- out_ready  in  1  decode accepts the head
- out_instr  out  M  head instruction word
- out_pc  out  AW  PC of head instruction
- out_op  out  2  out_instr[M-1:M-2], opcode field
- done  out  1  state is DONE and queue is empty

## Operation
- Queue: 2 entries of {pc, instr}, FIFO order, registered count 0..2.
  - Push occurs when state is RUN, count < 2 and no redirect. It writes {pc_out, mem_data}.
  - Pop occurs when out_valid && out_ready.
  - Simultaneous push and pop: count unchanged; ordering preserved.
- Push condition uses registered count only. There is no combinational path from out_ready to pc_out.
- States:
  - IDLE: reset state. No push. en=1 -> RUN.
  - RUN: each push sets pc_out <= pc_out+1 (mod 2^AW).
    - Push at pc_out==LAST_PC -> DONE, with pc_out <= 0.
    - en=0 -> IDLE. pc_out is held, queue retained and drains normally.
  - DONE: no push; en ignored. Leave only via redirect or reset.
- Redirect (highest priority, any state):
  - count <= 0 and pc_out <= redirect_pc.
  - Next state is RUN if en=1, else IDLE.
  - A push in the same cycle is discarded.
  - A pop in the same cycle is still a completed transfer from decode's view.
- out_instr, out_pc and out_op hold stable while out_valid && !out_ready.
- When count==0, out_instr/out_pc are don't-care; the bench checks them only when out_valid=1.

## Timing
- Reset (async, immediate): pc_out=0, count=0, out_valid=0, out_instr=0, out_pc=0, out_op=0, done=0, state=IDLE.
- Release of rst_n is synchronous to the next clk edge.
- en sampled high at edge k:
  - RUN from k.
  - First push at edge k+1.
  - out_valid=1 after edge k+1, i.e. 2-cycle latency from en to first instruction.
- Throughput: 1 instruction/cycle with out_ready held high. Count settles at 1.
- Backpressure: with out_ready=0, two more pushes happen, then fetch stalls with pc_out = head PC + 2.
- After a pop from count=2, a push resumes at the following edge.
- Redirect at edge r:
  - out_valid=0 after r.
  - First redirected instruction valid after r+1, if en=1.
- done rises the cycle after the last pop in DONE. It falls the cycle after redirect.
- pc_out wraps 2^AW-1 -> 0 only when LAST_PC < 2^AW-1 permits reaching it; with the default LAST_PC, DONE is reached first.
- Reset asserted mid-transfer drops the queue contents; no partial state survives.

## Test plan
- Reset mid-run: pull rst_n low between edges with count=2 -> all outputs 0 immediately, no further pushes until en sampled after release.
- Full stream: en=1, out_ready=1 -> out_pc = 0,1,…,31 on consecutive cycles starting 2 cycles after en, each out_instr equal to the memory word at that PC, out_op correct. done=1 the cycle after out_pc=31 is accepted.
- Backpressure: out_ready=0 from start -> count reaches 2, pc_out holds at 2, out_pc=0 stable. Raise out_ready -> 0,1,2,3… with no gap or duplicate.
- Redirect flush: with count=2 holding PCs 4,5, pulse redirect_valid with redirect_pc=17 -> out_valid=0 next cycle, next accepted out_pc=17, then 18; 4/5 never delivered.
- Redirect from DONE: after done=1, redirect to 30 with en=1 -> outputs 30, 31, then DONE again with done=1.
- Enable drop: deassert en with count=2 and out_ready=1 -> both queued entries drain, no new push. Reassert en -> fetch resumes at the held pc_out.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, drives the instruction memory
// address, and queues up to two {pc, instr} pairs for decode over a
// valid/ready handshake. A redirect flushes the queue and restarts fetch.
module instr_fetch #(
  parameter int M       = 32,
  parameter int AW      = 5,
  parameter int LAST_PC = 31
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic [AW-1:0] pc_out,
  input  logic [M-1:0]  mem_data,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [M-1:0]  out_instr,
  output logic [AW-1:0] out_pc,
  output logic [1:0]    out_op,
  output logic          done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [AW-1:0] LAST = LAST_PC[AW-1:0];

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          rd_q, rd_d;
  logic          wr_q, wr_d;

  logic [AW-1:0] qpc_q    [2];
  logic [M-1:0]  qinstr_q [2];

  logic push;
  logic pop;

  // Push depends only on registered state/count, so out_ready never
  // reaches pc_out combinationally; a redirect discards the push.
  assign push = (state_q == S_RUN) && (cnt_q != 2'd2) && !redirect_valid;
  assign pop  = out_valid && out_ready;

  // Next-state for FSM, PC and queue pointers; redirect overrides all.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    if (redirect_valid) begin
      state_d = en ? S_RUN : S_IDLE;
      pc_d    = redirect_pc;
      cnt_d   = 2'd0;
      rd_d    = 1'b0;
      wr_d    = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (en) state_d = S_RUN;
        end
        S_RUN: begin
          if (push && (pc_q == LAST)) begin
            state_d = S_DONE;
            pc_d    = '0;
          end else begin
            if (push) pc_d = pc_q + 1'b1;
            if (!en) state_d = S_IDLE;
          end
        end
        default: ;
      endcase
      if (push) wr_d = ~wr_q;
      if (pop)  rd_d = ~rd_q;
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + 2'd1;
        2'b01:   cnt_d = cnt_q - 2'd1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cnt_q   <= 2'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end

  // Queue storage; cleared on reset so the head reads zero afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qpc_q[0]    <= '0;
      qpc_q[1]    <= '0;
      qinstr_q[0] <= '0;
      qinstr_q[1] <= '0;
    end else if (push) begin
      qpc_q[wr_q]    <= pc_q;
      qinstr_q[wr_q] <= mem_data;
    end
  end

  assign pc_out    = pc_q;
  assign out_valid = (cnt_q != 2'd0);
  assign out_instr = qinstr_q[rd_q];
  assign out_pc    = qpc_q[rd_q];
  assign out_op    = out_instr[M-1:M-2];
  assign done      = (state_q == S_DONE) && (cnt_q == 2'd0);

endmodule
